// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Four-input round-robin arbiter feeding a single registered
//               output slot. The winning requester's word is captured one
//               cycle after its in_valid/in_ready handshake. The slot can be
//               refilled on the same edge it drains, so one word per cycle
//               is sustained while out_ready stays high.
//
// Ports       : clk        - single clock, rising edge
//               rst_n      - asynchronous active-low reset
//               in_valid   - per-requester valid (bit i = requester i)
//               in_data    - packed requester words, i at [i*DATA_W +: DATA_W]
//               in_ready   - one-hot (or zero) grant to the current winner
//               out_valid  - registered output word valid
//               out_data   - registered output word
//               out_sel    - index of the requester that supplied out_data
//               out_ready  - downstream accepts out_data while out_valid
//
// Parameters  : DATA_W     - width of each data channel
//               BURST_LEN  - maximum consecutive transfers per grant
//                            (only used in burst builds)
//
// Build macro : MUX4_ARB_BURST_EN - when defined, the current holder keeps
//               priority for up to BURST_LEN consecutive transfers. When
//               undefined, priority rotates to (winner+1) after every
//               transfer.
//
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          in_valid,
    input  logic [4*DATA_W-1:0] in_data,
    output logic [3:0]          in_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_data,
    output logic [1:0]          out_sel,
    input  logic                out_ready
);

    // ------------------------------------------------------------------
    // Unpack the requester words so they can be selected by index
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] chan_data [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_chan
        assign chan_data[gi] = in_data[gi*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        ptr_q,       ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [1:0]        out_sel_q,   out_sel_d;

`ifdef MUX4_ARB_BURST_EN
    // Wide enough to hold the value BURST_LEN itself, which is the count
    // reached on the final transfer of a burst.
    localparam int c_cnt_w = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_burst_max = c_cnt_w'(BURST_LEN);

    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic [c_cnt_w-1:0] cnt_inc;
`endif

    logic       slot_free;
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic       xfer;

    // ------------------------------------------------------------------
    // Arbitration and next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        slot_free = !out_valid_q || out_ready;

        // Walk the search order backwards so the last hit, which is the
        // one nearest to ptr, is the one that sticks.
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (in_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end

        // rst_n gates the grant so no handshake is offered while the
        // output register is held in reset.
        in_ready = 4'b0000;
        if (rst_n && slot_free && win_found) begin
            in_ready[win_idx] = 1'b1;
        end

        xfer = |(in_valid & in_ready);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[win_idx];
            out_sel_d   = win_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

`ifdef MUX4_ARB_BURST_EN
        // A transfer from a requester other than the holder starts a new
        // burst, so its count restarts from zero before incrementing.
        cnt_inc = ((win_idx == ptr_q) ? cnt_q : '0) + c_cnt_w'(1);
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            if (cnt_inc == c_burst_max) begin
                ptr_d = win_idx + 2'd1;
                cnt_d = '0;
            end else begin
                ptr_d = win_idx;
                cnt_d = cnt_inc;
            end
        end else if (slot_free && !in_valid[ptr_q]) begin
            // Holder went idle while it could have sent: give up priority.
            ptr_d = ptr_q + 2'd1;
            cnt_d = '0;
        end
`else
        ptr_d = xfer ? (win_idx + 2'd1) : ptr_q;
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= 2'd0;
`ifdef MUX4_ARB_BURST_EN
            cnt_q       <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifdef MUX4_ARB_BURST_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Self-checking bench for mux4_rr_arbiter. Directed scenarios
//               (reset, rotation, backpressure, sparse, idle) plus a
//               randomized run checked against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

    localparam int DW = 32;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      in_valid;
    logic [4*DW-1:0] in_data;
    logic [3:0]      in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_sel;
    logic            out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] data_c [4] = '{32'hAAAA0000, 32'hBBBB0000, 32'hCCCC0000, 32'hDDDD0000};

`ifdef MUX4_ARB_BURST_EN
    int exp_seq [5] = '{0, 0, 0, 0, 1};
`else
    int exp_seq [5] = '{0, 1, 2, 3, 0};
`endif

    // Reference model state
    int            m_ptr;
    int            m_cnt;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_sel;

    mux4_rr_arbiter #(.DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic void model_clear();
        m_ptr   = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 2'd0;
    endfunction

    function automatic int model_winner(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_ready(input logic [3:0] v, input logic ordy);
        logic [3:0] r;
        int w;
        r = 4'b0000;
        w = model_winner(v);
        if (rst_n === 1'b1 && (!m_valid || ordy) && w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    function automatic void model_clock(input logic [3:0] v, input logic ordy,
                                        input logic [4*DW-1:0] d);
        int   w;
        logic slot;
        int   c;
        w    = model_winner(v);
        slot = !m_valid || ordy;
        if (slot && w >= 0) begin
            m_valid = 1'b1;
            m_data  = d[w*DW +: DW];
            m_sel   = 2'(w);
`ifdef MUX4_ARB_BURST_EN
            c = ((w == m_ptr) ? m_cnt : 0) + 1;
            if (c == BL) begin
                m_ptr = (w + 1) % 4;
                m_cnt = 0;
            end else begin
                m_ptr = w;
                m_cnt = c;
            end
`else
            c     = 0;
            m_ptr = (w + 1) % 4;
`endif
        end else begin
            c = 0;
            if (ordy) m_valid = 1'b0;
`ifdef MUX4_ARB_BURST_EN
            if (slot && !v[m_ptr]) begin
                m_ptr = (m_ptr + 1) % 4;
                m_cnt = 0;
            end
`endif
        end
    endfunction

    // ------------------------------------------------------------------
    // Stimulus plumbing (no comparisons)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_clock(in_valid, out_ready, in_data);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        in_data   = {data_c[3], data_c[2], data_c[1], data_c[0]};
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = {data_c[3], data_c[2], data_c[1], data_c[0]};
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_checks++;
        if (out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        #2;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", in_ready); end
        tick();
        n_checks++;
        if (out_sel !== 2'd0 || out_data !== 32'hAAAA0000 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_word: got v=%b sel=%0d data=%h want v=1 sel=0 data=AAAA0000",
                     out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_reset_pre_valid: got %b want 1", out_valid); end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_in_ready: got %b want 0000", in_ready); end
        n_checks++;
        if (out_data !== '0 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset_word: got sel=%0d data=%h want sel=0 data=0", out_sel, out_data);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_reset_release: got %b want 0001", in_ready); end
    endtask

    task automatic test_rotation();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_checks++;
            if (in_ready !== 4'(1 << exp_seq[i])) begin
                n_fail++;
                $display("FAIL rotation_in_ready[%0d]: got %b want %b", i, in_ready, 4'(1 << exp_seq[i]));
            end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'(exp_seq[i]) || out_data !== data_c[exp_seq[i]]) begin
                n_fail++;
                $display("FAIL rotation_word[%0d]: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                         i, out_valid, out_sel, out_data, exp_seq[i], data_c[exp_seq[i]]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_rdy;
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_checks++;
            if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", i, in_ready); end
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hAAAA0000) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%b sel=%0d data=%h want v=1 sel=0 data=AAAA0000",
                         i, out_valid, out_sel, out_data);
            end
        end
        out_ready = 1'b1;
        #2;
        exp_rdy = model_ready(in_valid, out_ready);
        n_checks++;
        if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_release_ready: got %b want %b", in_ready, exp_rdy); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== m_sel || out_data !== data_c[m_sel]) begin
            n_fail++;
            $display("FAIL bp_release_word: got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                     out_valid, out_sel, out_data, m_sel, data_c[m_sel]);
        end
    endtask

    task automatic test_sparse_idle();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        #2;
        n_checks++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL sparse_ready2: got %b want 0100", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 32'hCCCC0000) begin
            n_fail++;
            $display("FAIL sparse_word2: got v=%b sel=%0d data=%h want v=1 sel=2 data=CCCC0000",
                     out_valid, out_sel, out_data);
        end
        in_valid = 4'b1001;
        #2;
        n_checks++;
        if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_ready3: got %b want 1000", in_ready); end
        tick();
        n_checks++;
        if (out_sel !== 2'd3 || out_data !== 32'hDDDD0000) begin
            n_fail++;
            $display("FAIL sparse_word3: got sel=%0d data=%h want sel=3 data=DDDD0000", out_sel, out_data);
        end
        // Idle cycle: the word drains and nothing replaces it
        in_valid = 4'b0000;
        #2;
        n_checks++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready: got %b want 0000", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || out_sel !== 2'd3 || out_data !== 32'hDDDD0000) begin
            n_fail++;
            $display("FAIL idle_drain: got v=%b sel=%0d data=%h want v=0 sel=3 data=DDDD0000",
                     out_valid, out_sel, out_data);
        end
        in_valid = 4'b1111;
        #2;
        n_checks++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL idle_ptr: got %b want 0001", in_ready); end
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_resume: got v=%b sel=%0d want v=1 sel=0", out_valid, out_sel);
        end
    endtask

    task automatic test_random();
        logic [3:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            #2;
            exp_rdy = model_ready(in_valid, out_ready);
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, exp_rdy);
            end
            tick();
            n_checks++;
            if (out_valid !== m_valid || out_sel !== m_sel || out_data !== m_data) begin
                n_fail++;
                $display("FAIL rand_out[%0d]: got v=%b sel=%0d data=%h want v=%b sel=%0d data=%h",
                         i, out_valid, out_sel, out_data, m_valid, m_sel, m_data);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_reset_midstream();
        test_rotation();
        test_backpressure();
        test_sparse_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
